// File: rtl/alu_share_ctrl_if.sv
// Request/response port between one requester and alu_share_ctrl.
// rsp_divz exists only when ALU_SHARE_CTRL_DIVZERO_EN is defined.
interface alu_share_ctrl_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FUNC_W = 4;

  logic              req_valid;
  logic              req_ready;
  logic [FUNC_W-1:0] req_func;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
  logic              rsp_divz;

  modport master (output req_valid, req_func, req_a, req_b,
                  input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_divz);
  modport slave  (input  req_valid, req_func, req_a, req_b,
                  output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_divz);
`else
  modport master (output req_valid, req_func, req_a, req_b,
                  input  req_ready, rsp_valid, rsp_result, rsp_zero);
  modport slave  (input  req_valid, req_func, req_a, req_b,
                  output req_ready, rsp_valid, rsp_result, rsp_zero);
`endif
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional divide-by-zero shortcut: define ALU_SHARE_CTRL_DIVZERO_EN.
module alu_share_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned RR_INIT       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_share_ctrl_if.slave         req0,
  alu_share_ctrl_if.slave         req1,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_func,
  input  logic [31:0]             alu_result,
  input  logic                    alu_z,
  output logic                    busy
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic             RR_RST  = 1'(RR_INIT);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pref, w_pref_nxt;
  logic              r_owner, w_owner_nxt;
  logic [31:0]       r_alu_a, w_alu_a_nxt;
  logic [31:0]       r_alu_b, w_alu_b_nxt;
  logic [3:0]        r_alu_func, w_alu_func_nxt;
  logic [1:0]        r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0][31:0]  r_rsp_result, w_rsp_result_nxt;
  logic [1:0]        r_rsp_zero, w_rsp_zero_nxt;
  logic              r_busy;

  logic              w_any;
  logic              w_grant;
  logic [3:0]        w_sel_func;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic              w_is_md;
  logic [31:0]       w_cap_result;
  logic              w_cap_zero;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
  logic              r_divz_op, w_divz_op_nxt;
  logic [1:0]        r_rsp_divz, w_rsp_divz_nxt;
  logic              w_sel_divz;
`endif

  // Arbitration: a lone requester wins, contention goes to the preferred one
  assign w_any      = req0.req_valid | req1.req_valid;
  assign w_grant    = (req0.req_valid && req1.req_valid) ? r_pref : req1.req_valid;
  assign w_sel_func = w_grant ? req1.req_func : req0.req_func;
  assign w_sel_a    = w_grant ? req1.req_a    : req0.req_a;
  assign w_sel_b    = w_grant ? req1.req_b    : req0.req_b;
  assign w_is_md    = (w_sel_func == 4'd3) || (w_sel_func == 4'd4) || (w_sel_func == 4'd5);

  assign req0.req_ready = (r_state == IDLE) && w_any && !w_grant;
  assign req1.req_ready = (r_state == IDLE) && w_any &&  w_grant;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pref_nxt       = r_pref;
    w_owner_nxt      = r_owner;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_func_nxt   = r_alu_func;
    w_rsp_valid_nxt  = 2'b00;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_cap_result     = alu_result;
    w_cap_zero       = alu_z;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
    w_divz_op_nxt    = r_divz_op;
    w_rsp_divz_nxt   = r_rsp_divz;
    w_sel_divz       = ((w_sel_func == 4'd4) || (w_sel_func == 4'd5)) && (w_sel_b == 32'd0);
    if (r_divz_op) begin
      w_cap_result = (r_alu_func == 4'd4) ? 32'hFFFF_FFFF : r_alu_a;
      w_cap_zero   = (w_cap_result == 32'd0);
    end
`endif

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_alu_a_nxt    = w_sel_a;
          w_alu_b_nxt    = w_sel_b;
          w_alu_func_nxt = w_sel_func;
          w_owner_nxt    = w_grant;
          w_pref_nxt     = !w_grant;
          w_cnt_nxt      = w_is_md ? MD_LOAD : CNT_W'(0);
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
          w_divz_op_nxt  = w_sel_divz;
          if (w_sel_divz) w_cnt_nxt = CNT_W'(0);
`endif
          w_state_nxt    = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt != CNT_W'(0)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_rsp_result_nxt[r_owner] = w_cap_result;
          w_rsp_zero_nxt[r_owner]   = w_cap_zero;
          w_rsp_valid_nxt[r_owner]  = 1'b1;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
          w_rsp_divz_nxt[r_owner]   = r_divz_op;
`endif
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pref       <= RR_RST;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_func   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= '0;
      r_busy       <= 1'b0;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
      r_divz_op    <= 1'b0;
      r_rsp_divz   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pref       <= w_pref_nxt;
      r_owner      <= w_owner_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_func   <= w_alu_func_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_busy       <= (w_state_nxt != IDLE);
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
      r_divz_op    <= w_divz_op_nxt;
      r_rsp_divz   <= w_rsp_divz_nxt;
`endif
    end
  end

  assign alu_a           = r_alu_a;
  assign alu_b           = r_alu_b;
  assign alu_func        = r_alu_func;
  assign busy            = r_busy;
  assign req0.rsp_valid  = r_rsp_valid[0];
  assign req1.rsp_valid  = r_rsp_valid[1];
  assign req0.rsp_result = r_rsp_result[0];
  assign req1.rsp_result = r_rsp_result[1];
  assign req0.rsp_zero   = r_rsp_zero[0];
  assign req1.rsp_zero   = r_rsp_zero[1];
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
  assign req0.rsp_divz   = r_rsp_divz[0];
  assign req1.rsp_divz   = r_rsp_divz[1];
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus random traffic against a
// transaction-level schedule model (accept time, latency, round-robin preference).
module tb_alu_share_ctrl;
  localparam int unsigned MC  = 4;
  localparam int unsigned RRI = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_func;
  logic        alu_z, busy;

  alu_share_ctrl_if if0 ();
  alu_share_ctrl_if if1 ();

  alu_share_ctrl #(.MULDIV_CYCLES(MC), .RR_INIT(RRI)) dut (
    .clk(clk), .rst_n(rst_n), .req0(if0), .req1(if1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_z(alu_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment ALU; codes 4/5 with b==0 return a marker so captures are visible
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a * b;
      4'd4:  return (b == 0) ? 32'hDEAD_BEEF : a / b;
      4'd5:  return (b == 0) ? 32'hDEAD_BEEF : a % b;
      4'd6:  return a | b;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd10: return a ^ b;
      4'd11: return {31'd0, ($signed(a) < $signed(b))};
      4'd12: return {31'd0, (a < b)};
      default: return a ^ {28'd0, f};
    endcase
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_func, alu_a, alu_b);
    alu_z      = (alu_result == 32'd0);
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  int          free_at = 0;
  int          rsp_at  = 0;
  bit          pend    = 1'b0;
  bit          pwho    = 1'b0;
  bit          pref    = 1'b0;
  logic [31:0] pres    = '0;
  bit          pz      = 1'b0;
  bit          pdz     = 1'b0;
  logic [31:0] exp_res [2];
  bit          exp_z   [2];
  bit          exp_dz  [2];
  logic [31:0] e_a = '0, e_b = '0;
  logic [3:0]  e_f = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0; pref = 1'(RRI);
    for (int i = 0; i < 2; i++) begin exp_res[i] = '0; exp_z[i] = 1'b0; exp_dz[i] = 1'b0; end
    e_a = '0; e_b = '0; e_f = '0;
    free_at = cyc + 1;
  endtask

  task automatic rst_step();
    @(negedge clk);
    rst_n = 1'b0;
    if0.req_valid = 1'b0; if1.req_valid = 1'b0;
    #1;
    cyc++;
    model_reset();
  endtask

  // One cycle: drive, check every output against the model, then advance the model
  task automatic step(input bit v0, input logic [3:0] f0, input logic [31:0] a0, input logic [31:0] b0,
                      input bit v1, input logic [3:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                      output bit acc0, output bit acc1);
    bit          idle, g, due, md;
    int          lat;
    logic [3:0]  f;
    logic [31:0] a, b;
    @(negedge clk);
    rst_n = 1'b1;
    if0.req_valid = v0; if0.req_func = f0; if0.req_a = a0; if0.req_b = b0;
    if1.req_valid = v1; if1.req_func = f1; if1.req_a = a1; if1.req_b = b1;
    #1;
    cyc++;
    due = pend && (cyc == rsp_at);
    if (due) begin exp_res[pwho] = pres; exp_z[pwho] = pz; exp_dz[pwho] = pdz; end
    idle = (cyc >= free_at);
    g    = (v0 && v1) ? pref : v1;
    acc0 = idle && (v0 || v1) && !g;
    acc1 = idle && (v0 || v1) &&  g;
    check("ready0",  32'(if0.req_ready), 32'(acc0));
    check("ready1",  32'(if1.req_ready), 32'(acc1));
    check("rsp0_valid", 32'(if0.rsp_valid), 32'(due && !pwho));
    check("rsp1_valid", 32'(if1.rsp_valid), 32'(due &&  pwho));
    check("rsp0_result", if0.rsp_result, exp_res[0]);
    check("rsp1_result", if1.rsp_result, exp_res[1]);
    check("rsp0_zero", 32'(if0.rsp_zero), 32'(exp_z[0]));
    check("rsp1_zero", 32'(if1.rsp_zero), 32'(exp_z[1]));
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
    check("rsp0_divz", 32'(if0.rsp_divz), 32'(exp_dz[0]));
    check("rsp1_divz", 32'(if1.rsp_divz), 32'(exp_dz[1]));
`endif
    check("busy", 32'(busy), 32'(cyc < free_at));
    check("alu_a", alu_a, e_a);
    check("alu_b", alu_b, e_b);
    check("alu_func", 32'(alu_func), 32'(e_f));
    if (due) pend = 1'b0;
    if (acc0 || acc1) begin
      f = g ? f1 : f0; a = g ? a1 : a0; b = g ? b1 : b0;
      md   = (f == 4'd3) || (f == 4'd4) || (f == 4'd5);
      lat  = md ? int'(MC) + 1 : 2;
      pres = ref_alu(f, a, b);
      pdz  = 1'b0;
`ifdef ALU_SHARE_CTRL_DIVZERO_EN
      if ((f == 4'd4 || f == 4'd5) && b == 32'd0) begin
        lat = 2; pdz = 1'b1;
        pres = (f == 4'd4) ? 32'hFFFF_FFFF : a;
      end
`endif
      pz = (pres == 32'd0);
      pend = 1'b1; pwho = g; rsp_at = cyc + lat; free_at = cyc + lat + 1;
      pref = !g;
      e_a = a; e_b = b; e_f = f;
    end
  endtask

  task automatic idle_step();
    bit x0, x1;
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, x0, x1);
  endtask

  bit          hv [2];
  logic [3:0]  hf [2];
  logic [31:0] ha [2], hb [2];

  initial begin
    bit k0, k1, d0, d1;
    int gq [$];
    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.req_func = '0; if0.req_a = '0; if0.req_b = '0;
    if1.req_valid = 1'b0; if1.req_func = '0; if1.req_a = '0; if1.req_b = '0;
    repeat (2) rst_step();

    // Single add from requester 0
    step(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, k0, k1);
    check("t1_ready0", 32'(if0.req_ready), 32'd1);
    idle_step();
    check("t1_early_rsp", 32'(if0.rsp_valid), 32'd0);
    idle_step();
    check("t1_rsp_valid", 32'(if0.rsp_valid), 32'd1);
    check("t1_result", if0.rsp_result, 32'd12);
    idle_step();

    // Contention straight after reset: requester 0 first
    rst_step();
    d0 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 20 && !(d0 && d1); i++) begin
      step(!d0, 4'd1, 32'd9, 32'd9, !d1, 4'd10, 32'd3, 32'd3, k0, k1);
      if (i == 0) check("t2_first_grant", 32'(if0.req_ready), 32'd1);
      d0 |= k0; d1 |= k1;
    end
    repeat (4) idle_step();
    check("t2_zero0", 32'(if0.rsp_zero), 32'd1);
    check("t2_zero1", 32'(if1.rsp_zero), 32'd1);

    // Back-to-back alternation
    rst_step();
    for (int i = 0; i < 40 && gq.size() < 6; i++) begin
      step(1'b1, 4'd0, 32'(i), 32'd1, 1'b1, 4'd2, 32'(i), 32'hFF, k0, k1);
      if (k0) gq.push_back(0);
      if (k1) gq.push_back(1);
    end
    for (int i = 0; i < 6; i++) check("t3_grant_order", 32'(gq[i]), 32'(i % 2));
    repeat (3) idle_step();

    // Multiply on requester 1 while requester 0 waits
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd3, 32'd6, 32'd7, k0, k1);
    for (int i = 1; i <= int'(MC) + 1; i++) begin
      step(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, k0, k1);
      check("t4_ready0_blocked", 32'(if0.req_ready), 32'd0);
      if (i == int'(MC) + 1) begin
        check("t4_rsp1_valid", 32'(if1.rsp_valid), 32'd1);
        check("t4_result", if1.rsp_result, 32'd42);
      end
    end
    repeat (3) idle_step();

    // Reset in the middle of a divide
    step(1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, k0, k1);
    idle_step();
    rst_step();
    idle_step();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_res1", if1.rsp_result, 32'd0);
    step(1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, k0, k1);
    repeat (2) idle_step();
    check("t5_after_rst", if0.rsp_result, 32'd3);
    repeat (2) idle_step();

`ifdef ALU_SHARE_CTRL_DIVZERO_EN
    step(1'b1, 4'd4, 32'd10, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, k0, k1);
    repeat (2) idle_step();
    check("t6_div0_res", if0.rsp_result, 32'hFFFF_FFFF);
    check("t6_div0_flag", 32'(if0.rsp_divz), 32'd1);
    idle_step();
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd5, 32'd10, 32'd0, k0, k1);
    repeat (2) idle_step();
    check("t6_rem0_res", if1.rsp_result, 32'd10);
    check("t6_rem0_flag", 32'(if1.rsp_divz), 32'd1);
    idle_step();
`endif

    // Random traffic
    for (int i = 0; i < 2; i++) hv[i] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_step();
        continue;
      end
      for (int i = 0; i < 2; i++) begin
        if (hv[i] && $urandom_range(0, 19) == 0) hv[i] = 1'b0;
        if (!hv[i] && $urandom_range(0, 2) == 0) begin
          hv[i] = 1'b1;
          hf[i] = 4'($urandom_range(0, 15));
          ha[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          hb[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        end
      end
      step(hv[0], hf[0], ha[0], hb[0], hv[1], hf[1], ha[1], hb[1], k0, k1);
      if (k0) hv[0] = 1'b0;
      if (k1) hv[1] = 1'b0;
    end
    repeat (int'(MC) + 3) idle_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
